serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor_if.sv | 23 ++
 rtl/serial_subtractor.sv | 149 ++++++++++++++
 tb/tb_serial_subtractor.sv | 371 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_if.sv
// Start/done handshake bundle for serial_subtractor.
// The ovf signal exists only when SERIAL_SUB_OVF_EN is defined.
interface serial_subtractor_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;

    modport master (output start, a, b, bin, input  busy, done, diff, bout, ovf);
    modport slave  (input  start, a, b, bin, output busy, done, diff, bout, ovf);
`else
    modport master (output start, a, b, bin, input  busy, done, diff, bout);
    modport slave  (input  start, a, b, bin, output busy, done, diff, bout);
`endif
endinterface

// File: rtl/serial_subtractor.sv
// Digit-serial WIDTH-bit subtractor: diff = a - b - bin, DIGIT bits per clock, LSB first.
// Define SERIAL_SUB_OVF_EN to add the two's-complement overflow output ovf.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_subtractor_if.slave sub
);

    localparam int unsigned N     = WIDTH / DIGIT;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             borrow_q, borrow_d;
    logic             bout_q, bout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [DIGIT:0]   dig_res;
    logic [WIDTH-1:0] acc_shift;
    logic             last_dig;

`ifdef SERIAL_SUB_OVF_EN
    logic a_msb_q, a_msb_d;
    logic b_msb_q, b_msb_d;
    logic ovf_q, ovf_d;
`endif

    // One digit of the borrow chain; the top bit is the digit borrow-out.
    always_comb begin
        dig_res   = {1'b0, a_q[DIGIT-1:0]} - {1'b0, b_q[DIGIT-1:0]} - (DIGIT+1)'(borrow_q);
        acc_shift = (acc_q >> DIGIT) | (WIDTH'(dig_res[DIGIT-1:0]) << (WIDTH - DIGIT));
        last_dig  = (cnt_q == CNT_W'(N - 1));
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        diff_d   = diff_q;
        cnt_d    = cnt_q;
        borrow_d = borrow_q;
        bout_d   = bout_q;
`ifdef SERIAL_SUB_OVF_EN
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        ovf_d    = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (sub.start) begin
                    a_d      = sub.a;
                    b_d      = sub.b;
                    borrow_d = sub.bin;
                    acc_d    = '0;
                    cnt_d    = '0;
`ifdef SERIAL_SUB_OVF_EN
                    a_msb_d  = sub.a[WIDTH-1];
                    b_msb_d  = sub.b[WIDTH-1];
`endif
                    state_d  = RUN;
                end
            end
            RUN: begin
                a_d      = a_q >> DIGIT;
                b_d      = b_q >> DIGIT;
                borrow_d = dig_res[DIGIT];
                acc_d    = acc_shift;
                cnt_d    = cnt_q + CNT_W'(1);
                // Results become visible only once the whole word is assembled.
                if (last_dig) begin
                    diff_d  = acc_shift;
                    bout_d  = dig_res[DIGIT];
                    cnt_d   = '0;
`ifdef SERIAL_SUB_OVF_EN
                    ovf_d   = (a_msb_q != b_msb_q) && (acc_shift[WIDTH-1] != a_msb_q);
`endif
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            bout_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            diff_q   <= diff_d;
            cnt_q    <= cnt_d;
            borrow_q <= borrow_d;
            bout_q   <= bout_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            ovf_q   <= ovf_d;
        end
    end

    assign sub.ovf = ovf_q;
`endif

    assign sub.busy = busy_q;
    assign sub.done = done_q;
    assign sub.diff = diff_q;
    assign sub.bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: three instances (8/1, 16/4, 8/2) against an
// arithmetic reference model; ovf is checked when SERIAL_SUB_OVF_EN is defined.
module tb_serial_subtractor;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cur      = 0;

    logic        drv_start = 1'b0;
    logic [15:0] drv_a     = '0;
    logic [15:0] drv_b     = '0;
    logic        drv_bin   = 1'b0;

    serial_subtractor_if #(.WIDTH(8))  if8  ();
    serial_subtractor_if #(.WIDTH(16)) if16 ();
    serial_subtractor_if #(.WIDTH(8))  if82 ();

    assign if8.start  = drv_start && (cur == 0);
    assign if8.a      = drv_a[7:0];
    assign if8.b      = drv_b[7:0];
    assign if8.bin    = drv_bin;
    assign if16.start = drv_start && (cur == 1);
    assign if16.a     = drv_a;
    assign if16.b     = drv_b;
    assign if16.bin   = drv_bin;
    assign if82.start = drv_start && (cur == 2);
    assign if82.a     = drv_a[7:0];
    assign if82.b     = drv_b[7:0];
    assign if82.bin   = drv_bin;

    serial_subtractor #(.WIDTH(8),  .DIGIT(1)) dut8  (.clk(clk), .rst_n(rst_n), .sub(if8));
    serial_subtractor #(.WIDTH(16), .DIGIT(4)) dut16 (.clk(clk), .rst_n(rst_n), .sub(if16));
    serial_subtractor #(.WIDTH(8),  .DIGIT(2)) dut82 (.clk(clk), .rst_n(rst_n), .sub(if82));

    logic [15:0] m_diff;
    logic        m_busy, m_done, m_bout, m_ovf;

    always_comb begin
        m_ovf = 1'b0;
        case (cur)
            1: begin
                m_diff = if16.diff; m_busy = if16.busy; m_done = if16.done; m_bout = if16.bout;
`ifdef SERIAL_SUB_OVF_EN
                m_ovf  = if16.ovf;
`endif
            end
            2: begin
                m_diff = {8'h00, if82.diff}; m_busy = if82.busy; m_done = if82.done; m_bout = if82.bout;
`ifdef SERIAL_SUB_OVF_EN
                m_ovf  = if82.ovf;
`endif
            end
            default: begin
                m_diff = {8'h00, if8.diff}; m_busy = if8.busy; m_done = if8.done; m_bout = if8.bout;
`ifdef SERIAL_SUB_OVF_EN
                m_ovf  = if8.ovf;
`endif
            end
        endcase
    end

    function automatic int width_of(input int s);
        return (s == 1) ? 16 : 8;
    endfunction

    function automatic int n_of(input int s);
        return (s == 0) ? 8 : 4;
    endfunction

    // Reference: plain integer subtraction, unsigned for diff/bout, signed range for ovf.
    function automatic void model(input int w, input logic [15:0] a, input logic [15:0] b,
                                  input logic bin, output logic [15:0] d, output logic bo,
                                  output logic ov);
        longint r, sa, sb, sr, half, full;
        full = longint'(1) << w;
        half = longint'(1) << (w - 1);
        r    = longint'(a) - longint'(b) - longint'(bin);
        d    = 16'(r & (full - 1));
        bo   = (r < 0);
        sa   = (longint'(a) >= half) ? longint'(a) - full : longint'(a);
        sb   = (longint'(b) >= half) ? longint'(b) - full : longint'(b);
        sr   = sa - sb - longint'(bin);
        ov   = (sr < -half) || (sr >= half);
    endfunction

    // One operation on instance cur; reports results, done latency in edges after accept,
    // and whether busy/done/result-hold behaved around it.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic bin,
                          output logic [15:0] d, output logic bo, output logic ov,
                          output int lat, output bit proto_ok);
        logic [15:0] prev_diff;
        lat      = -1;
        proto_ok = 1'b1;
        @(negedge clk);
        prev_diff = m_diff;
        drv_a = a; drv_b = b; drv_bin = bin; drv_start = 1'b1;
        @(posedge clk); #1;
        drv_start = 1'b0;
        if (!m_busy) proto_ok = 1'b0;
        for (int e = 1; e <= 60 && lat < 0; e++) begin
            @(posedge clk); #1;
            drv_a = 16'($urandom); drv_b = 16'($urandom); drv_bin = 1'($urandom);
            if (m_done) lat = e;
            else if (!m_busy || m_diff !== prev_diff) proto_ok = 1'b0;
        end
        d  = m_diff;
        bo = m_bout;
        ov = m_ovf;
        @(posedge clk); #1;
        if (m_done || m_busy) proto_ok = 1'b0;
    endtask

    task automatic test_reset();
        cur = 0;
        #1;
        checks++;
        if ({m_busy, m_done, m_bout} !== 3'b000 || m_diff !== 16'h0) begin
            failures++;
            $display("FAIL reset_outputs: got busy=%b done=%b bout=%b diff=%h required all zero",
                     m_busy, m_done, m_bout, m_diff);
        end
        checks++;
        if (if16.busy !== 1'b0 || if16.diff !== 16'h0 || if82.busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_other_inst: got busy16=%b diff16=%h busy82=%b required 0",
                     if16.busy, if16.diff, if82.busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed_8x1();
        logic [15:0] va [4] = '{16'h05, 16'h03, 16'h00, 16'hFF};
        logic [15:0] vb [4] = '{16'h03, 16'h05, 16'h00, 16'hFF};
        logic        vc [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [15:0] ed [4] = '{16'h02, 16'hFE, 16'hFF, 16'hFF};
        logic        eb [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        logic [15:0] d;
        logic bo, ov;
        int lat;
        bit ok;
        cur = 0;
        for (int i = 0; i < 4; i++) begin
            run_op(va[i], vb[i], vc[i], d, bo, ov, lat, ok);
            checks++;
            if (d !== ed[i] || bo !== eb[i]) begin
                failures++;
                $display("FAIL directed8_%0d: got diff=%h bout=%b required diff=%h bout=%b",
                         i, d, bo, ed[i], eb[i]);
            end
            checks++;
            if (lat !== 8 || !ok) begin
                failures++;
                $display("FAIL directed8_timing_%0d: got latency=%0d proto_ok=%0b required 8 and 1",
                         i, lat, ok);
            end
        end
    endtask

    task automatic test_abort();
        logic [15:0] d;
        logic bo, ov;
        int lat;
        bit ok;
        cur = 0;
        @(negedge clk);
        drv_a = 16'hAA; drv_b = 16'h11; drv_bin = 1'b0; drv_start = 1'b1;
        @(posedge clk); #1;
        drv_start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({m_busy, m_done, m_bout} !== 3'b000 || m_diff !== 16'h0) begin
            failures++;
            $display("FAIL abort_reset: got busy=%b done=%b bout=%b diff=%h required all zero",
                     m_busy, m_done, m_bout, m_diff);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (m_busy !== 1'b0 || m_done !== 1'b0) begin
            failures++;
            $display("FAIL abort_idle: got busy=%b done=%b required 0 0", m_busy, m_done);
        end
        run_op(16'h10, 16'h01, 1'b0, d, bo, ov, lat, ok);
        checks++;
        if (d !== 16'h0F || bo !== 1'b0 || lat !== 8 || !ok) begin
            failures++;
            $display("FAIL abort_recover: got diff=%h bout=%b lat=%0d ok=%0b required 0f 0 8 1",
                     d, bo, lat, ok);
        end
    endtask

    task automatic test_start_held();
        int n, period, total, dones, last;
        bit spacing_ok;
        logic [15:0] qd [$];
        logic        qb [$];
        logic [15:0] d, ed;
        logic bo, eb, ov;
        cur = 0;
        n = n_of(0); period = n + 2; total = 3 * period;
        dones = 0; last = -1; spacing_ok = 1'b1;
        @(negedge clk);
        drv_start = 1'b1;
        for (int e = 0; e < total; e++) begin
            drv_a = 16'($urandom_range(0, 255));
            drv_b = 16'($urandom_range(0, 255));
            drv_bin = 1'($urandom);
            if (e % period == 0) begin
                model(8, drv_a, drv_b, drv_bin, ed, eb, ov);
                qd.push_back(ed);
                qb.push_back(eb);
            end
            @(posedge clk); #1;
            if (m_done) begin
                dones++;
                if (last >= 0 && e - last != period) spacing_ok = 1'b0;
                last = e;
                checks++;
                if (qd.size() == 0) begin
                    failures++;
                    $display("FAIL held_result: got done at edge %0d required no done", e);
                end else begin
                    ed = qd.pop_front();
                    eb = qb.pop_front();
                    d  = m_diff;
                    bo = m_bout;
                    if (d !== ed || bo !== eb) begin
                        failures++;
                        $display("FAIL held_result: got diff=%h bout=%b required diff=%h bout=%b",
                                 d, bo, ed, eb);
                    end
                end
            end
            @(negedge clk);
        end
        drv_start = 1'b0;
        checks++;
        if (dones !== 3 || !spacing_ok) begin
            failures++;
            $display("FAIL held_pulses: got dones=%0d spacing_ok=%0b required 3 and 1",
                     dones, spacing_ok);
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic test_wide_16x4();
        logic [15:0] d, ed, a, b;
        logic bo, eb, ov, eo, bin;
        int lat, bad_val, bad_tim;
        bit ok;
        cur = 1;
        run_op(16'h1234, 16'h0235, 1'b0, d, bo, ov, lat, ok);
        checks++;
        if (d !== 16'h0FFF || bo !== 1'b0 || lat !== 4 || !ok) begin
            failures++;
            $display("FAIL wide_directed: got diff=%h bout=%b lat=%0d ok=%0b required 0fff 0 4 1",
                     d, bo, lat, ok);
        end
        bad_val = 0; bad_tim = 0;
        for (int i = 0; i < 1000; i++) begin
            a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom);
            if (i < 4) begin
                a = (i[0]) ? 16'hFFFF : 16'h0000;
                b = (i[1]) ? 16'hFFFF : 16'h0000;
            end
            model(16, a, b, bin, ed, eb, eo);
            run_op(a, b, bin, d, bo, ov, lat, ok);
            checks++;
            if (d !== ed || bo !== eb) begin
                failures++;
                if (bad_val < 5)
                    $display("FAIL wide_random: %h-%h-%b got diff=%h bout=%b required diff=%h bout=%b",
                             a, b, bin, d, bo, ed, eb);
                bad_val++;
            end
            checks++;
            if (lat !== 4 || !ok) begin
                failures++;
                if (bad_tim < 5)
                    $display("FAIL wide_timing: got lat=%0d ok=%0b required 4 1", lat, ok);
                bad_tim++;
            end
        end
    endtask

    task automatic test_random_8bit();
        logic [15:0] d, ed, a, b;
        logic bo, eb, ov, eo, bin;
        int lat, bad;
        bit ok;
        bad = 0;
        for (int s = 0; s < 3; s += 2) begin
            cur = s;
            for (int i = 0; i < 150; i++) begin
                a = 16'($urandom_range(0, 255)); b = 16'($urandom_range(0, 255)); bin = 1'($urandom);
                model(width_of(s), a, b, bin, ed, eb, eo);
                run_op(a, b, bin, d, bo, ov, lat, ok);
                checks++;
                if (d !== ed || bo !== eb || lat !== n_of(s) || !ok) begin
                    failures++;
                    if (bad < 5)
                        $display("FAIL rand8_inst%0d: %h-%h-%b got diff=%h bout=%b lat=%0d ok=%0b required diff=%h bout=%b lat=%0d",
                                 s, a, b, bin, d, bo, lat, ok, ed, eb, n_of(s));
                    bad++;
                end
`ifdef SERIAL_SUB_OVF_EN
                checks++;
                if (ov !== eo) begin
                    failures++;
                    $display("FAIL rand8_ovf_inst%0d: %h-%h-%b got ovf=%b required %b",
                             s, a, b, bin, ov, eo);
                end
`endif
            end
        end
    endtask

    task automatic test_ovf_8x2();
        logic [15:0] va [3] = '{16'h80, 16'h7F, 16'h10};
        logic [15:0] vb [3] = '{16'h01, 16'hFF, 16'h05};
        logic [15:0] ed [3] = '{16'h7F, 16'h80, 16'h0B};
        logic        eb [3] = '{1'b0, 1'b1, 1'b0};
        logic        eo [3] = '{1'b1, 1'b1, 1'b0};
        logic [15:0] d;
        logic bo, ov;
        int lat;
        bit ok;
        cur = 2;
        for (int i = 0; i < 3; i++) begin
            run_op(va[i], vb[i], 1'b0, d, bo, ov, lat, ok);
            checks++;
            if (d !== ed[i] || bo !== eb[i] || lat !== 4 || !ok) begin
                failures++;
                $display("FAIL ovf_vec_%0d: got diff=%h bout=%b lat=%0d ok=%0b required diff=%h bout=%b lat=4",
                         i, d, bo, lat, ok, ed[i], eb[i]);
            end
`ifdef SERIAL_SUB_OVF_EN
            checks++;
            if (ov !== eo[i]) begin
                failures++;
                $display("FAIL ovf_flag_%0d: got ovf=%b required %b", i, ov, eo[i]);
            end
`else
            if (eo[i] === 1'bx) $display("unreachable");
`endif
        end
    endtask

    initial begin
        test_reset();
        test_directed_8x1();
        test_abort();
        test_start_held();
        test_wide_16x4();
        test_random_8bit();
        test_ovf_8x2();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
